// File: rtl/iob_sprite_engine.sv
// -----------------------------------------------------------------------------
// iob_sprite_engine
//
// Purpose:
//   Renders N_SPRITES rectangular sprites over a background colour. The CPU
//   writes sprite fields into shadow registers. The shadow set is copied into
//   the active set on frame_start, so a frame never shows half an update.
//   Pixels pass through a registered 2-stage pipeline: a hit test, then the
//   output register. Per-frame sticky collision flags and a committed frame
//   counter are provided for game logic.
//
// Ports:
//   clk          system clock
//   rst          synchronous active-high reset
//   cfg_we       shadow register write strobe
//   cfg_addr     {sprite index, field}; field 0=LOC, 1=SIZE, 2=COLOR, 3=ignored
//   cfg_wdata    write data
//                  LOC:   x=[COORD_W-1:0], y=[2*COORD_W-1:COORD_W]
//                  SIZE:  hx=[7:0], hy=[15:8]
//                  COLOR: rgb=[RGB_W-1:0], enable=[31]
//   frame_start  one-cycle pulse at start of vertical blank (commit point)
//   pixel_valid  pixel_x/pixel_y valid this cycle
//   pixel_x/y    current pixel coordinates
//   rgb          pixel colour, two cycles after the pixel (BG_RGB when idle)
//   rgb_valid    pixel_valid delayed by two cycles
//   coll_status  collision flags of the last completed frame
//   frame_cnt    number of commits since reset (wraps at 16 bits)
// -----------------------------------------------------------------------------
module iob_sprite_engine #(
  parameter int               N_SPRITES = 4,
  parameter int               COORD_W   = 10,
  parameter int               RGB_W     = 12,
  parameter logic [RGB_W-1:0] BG_RGB    = '0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          cfg_we,
  input  logic [$clog2(N_SPRITES)+1:0]  cfg_addr,
  input  logic [31:0]                   cfg_wdata,
  input  logic                          frame_start,
  input  logic                          pixel_valid,
  input  logic [COORD_W-1:0]            pixel_x,
  input  logic [COORD_W-1:0]            pixel_y,
  output logic [RGB_W-1:0]              rgb,
  output logic                          rgb_valid,
  output logic [N_SPRITES-1:0]          coll_status,
  output logic [15:0]                   frame_cnt
);

  localparam int AW = $clog2(N_SPRITES) + 2;
  // Wide enough that coord+half-size never wraps, whichever of the two is wider.
  localparam int EW = ((COORD_W > 8) ? COORD_W : 8) + 1;

  localparam logic [1:0] FIELD_LOC   = 2'd0;
  localparam logic [1:0] FIELD_SIZE  = 2'd1;
  localparam logic [1:0] FIELD_COLOR = 2'd2;

  logic [COORD_W-1:0] sh_x   [N_SPRITES];
  logic [COORD_W-1:0] sh_y   [N_SPRITES];
  logic [7:0]         sh_hx  [N_SPRITES];
  logic [7:0]         sh_hy  [N_SPRITES];
  logic [RGB_W-1:0]   sh_rgb [N_SPRITES];
  logic               sh_en  [N_SPRITES];

  logic [COORD_W-1:0] act_x   [N_SPRITES];
  logic [COORD_W-1:0] act_y   [N_SPRITES];
  logic [7:0]         act_hx  [N_SPRITES];
  logic [7:0]         act_hy  [N_SPRITES];
  logic [RGB_W-1:0]   act_rgb [N_SPRITES];
  logic               act_en  [N_SPRITES];

  logic [COORD_W-1:0] eff_x   [N_SPRITES];
  logic [COORD_W-1:0] eff_y   [N_SPRITES];
  logic [7:0]         eff_hx  [N_SPRITES];
  logic [7:0]         eff_hy  [N_SPRITES];
  logic [RGB_W-1:0]   eff_rgb [N_SPRITES];
  logic               eff_en  [N_SPRITES];

  logic [AW-1:0]        cfg_sprite;
  logic [1:0]           cfg_field;
  logic [N_SPRITES-1:0] hit_c;
  logic [RGB_W-1:0]     sel_rgb;
  logic                 s1_valid;
  logic [N_SPRITES-1:0] s1_hit;
  logic [RGB_W-1:0]     s1_rgb;
  logic [N_SPRITES-1:0] coll_now;
  logic [N_SPRITES-1:0] coll_acc;
  logic                 unused_wdata;

  assign cfg_sprite   = cfg_addr >> 2;
  assign cfg_field    = cfg_addr[1:0];
  // Gathers write-data bits that no field decodes.
  assign unused_wdata = ^cfg_wdata;

  // True when p lies within c-h .. c+h, with the low edge clamped at 0 and
  // the high edge allowed to run past the screen instead of wrapping.
  function automatic logic in_span(input logic [COORD_W-1:0] c,
                                   input logic [7:0]         h,
                                   input logic [COORD_W-1:0] p);
    logic [EW-1:0] ce, he, pe, lo, hi;
    ce = EW'(c);
    he = EW'(h);
    pe = EW'(p);
    lo = (ce >= he) ? (ce - he) : '0;
    hi = ce + he;
    return (pe >= lo) && (pe <= hi);
  endfunction

  // CPU writes land in the shadow set only. A write in the frame_start cycle
  // lands after the commit copy, so it waits for the following commit.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_SPRITES; i++) begin
        sh_x[i]   <= '0;
        sh_y[i]   <= '0;
        sh_hx[i]  <= '0;
        sh_hy[i]  <= '0;
        sh_rgb[i] <= '0;
        sh_en[i]  <= 1'b0;
      end
    end else if (cfg_we) begin
      for (int i = 0; i < N_SPRITES; i++) begin
        if (cfg_sprite == AW'(i)) begin
          case (cfg_field)
            FIELD_LOC: begin
              sh_x[i] <= cfg_wdata[COORD_W-1:0];
              sh_y[i] <= cfg_wdata[2*COORD_W-1:COORD_W];
            end
            FIELD_SIZE: begin
              sh_hx[i] <= cfg_wdata[7:0];
              sh_hy[i] <= cfg_wdata[15:8];
            end
            FIELD_COLOR: begin
              sh_rgb[i] <= cfg_wdata[RGB_W-1:0];
              sh_en[i]  <= cfg_wdata[31];
            end
            default: ;
          endcase
        end
      end
    end
  end

  // Commit the whole shadow set at frame start.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_SPRITES; i++) begin
        act_x[i]   <= '0;
        act_y[i]   <= '0;
        act_hx[i]  <= '0;
        act_hy[i]  <= '0;
        act_rgb[i] <= '0;
        act_en[i]  <= 1'b0;
      end
    end else if (frame_start) begin
      for (int i = 0; i < N_SPRITES; i++) begin
        act_x[i]   <= sh_x[i];
        act_y[i]   <= sh_y[i];
        act_hx[i]  <= sh_hx[i];
        act_hy[i]  <= sh_hy[i];
        act_rgb[i] <= sh_rgb[i];
        act_en[i]  <= sh_en[i];
      end
    end
  end

  // A pixel arriving together with frame_start already sees the values being
  // committed, so the hit test reads the shadow set in that cycle.
  always_comb begin
    for (int i = 0; i < N_SPRITES; i++) begin
      eff_x[i]   = frame_start ? sh_x[i]   : act_x[i];
      eff_y[i]   = frame_start ? sh_y[i]   : act_y[i];
      eff_hx[i]  = frame_start ? sh_hx[i]  : act_hx[i];
      eff_hy[i]  = frame_start ? sh_hy[i]  : act_hy[i];
      eff_rgb[i] = frame_start ? sh_rgb[i] : act_rgb[i];
      eff_en[i]  = frame_start ? sh_en[i]  : act_en[i];
    end
  end

  // Hit test and priority pick. Walking from the top index down leaves the
  // lowest-index hit as the winner. The winning colour is captured with the
  // pixel so a commit while the pixel is in flight cannot recolour it.
  always_comb begin
    hit_c   = '0;
    sel_rgb = BG_RGB;
    for (int i = N_SPRITES - 1; i >= 0; i--) begin
      hit_c[i] = pixel_valid && eff_en[i] &&
                 in_span(eff_x[i], eff_hx[i], pixel_x) &&
                 in_span(eff_y[i], eff_hy[i], pixel_y);
      if (hit_c[i]) begin
        sel_rgb = eff_rgb[i];
      end
    end
  end

  // Stage 1 register: validity, hit vector and winning colour.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_hit   <= '0;
      s1_rgb   <= BG_RGB;
    end else begin
      s1_valid <= pixel_valid;
      s1_hit   <= hit_c;
      s1_rgb   <= sel_rgb;
    end
  end

  // Stage 2 register: bubbles show the background colour.
  always_ff @(posedge clk) begin
    if (rst) begin
      rgb_valid <= 1'b0;
      rgb       <= BG_RGB;
    end else begin
      rgb_valid <= s1_valid;
      rgb       <= s1_valid ? s1_rgb : BG_RGB;
    end
  end

  // A sprite collides when it is hit together with at least one other sprite.
  always_comb begin
    coll_now = '0;
    for (int i = 0; i < N_SPRITES; i++) begin
      coll_now[i] = s1_valid && s1_hit[i] &&
                    ((s1_hit & ~(N_SPRITES'(1) << i)) != '0);
    end
  end

  // Sticky collision accumulator and frame counter. At frame start the
  // finished frame's flags are published and the accumulator restarts with
  // whatever collides in that very cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      coll_acc    <= '0;
      coll_status <= '0;
      frame_cnt   <= '0;
    end else if (frame_start) begin
      coll_status <= coll_acc;
      coll_acc    <= coll_now;
      frame_cnt   <= frame_cnt + 16'd1;
    end else begin
      coll_acc    <= coll_acc | coll_now;
    end
  end

endmodule

// File: tb/tb_iob_sprite_engine.sv
// -----------------------------------------------------------------------------
// tb_iob_sprite_engine
//
// Purpose:
//   Self-checking bench for iob_sprite_engine. A behavioural model keeps the
//   sprite sets as plain integers and predicts rgb, rgb_valid, coll_status and
//   frame_cnt every cycle. Directed scenarios with hand-computed colours pin
//   the model, then a randomized phase exercises writes, commits, bubbles
//   and resets.
// -----------------------------------------------------------------------------
module tb_iob_sprite_engine;

  localparam int          N  = 4;
  localparam logic [11:0] BG = 12'h000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_we = 1'b0;
  logic [3:0]  cfg_addr = '0;
  logic [31:0] cfg_wdata = '0;
  logic        frame_start = 1'b0;
  logic        pixel_valid = 1'b0;
  logic [9:0]  pixel_x = '0;
  logic [9:0]  pixel_y = '0;
  logic [11:0] rgb;
  logic        rgb_valid;
  logic [3:0]  coll_status;
  logic [15:0] frame_cnt;

  iob_sprite_engine #(
    .N_SPRITES(N),
    .COORD_W  (10),
    .RGB_W    (12),
    .BG_RGB   (BG)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_we     (cfg_we),
    .cfg_addr   (cfg_addr),
    .cfg_wdata  (cfg_wdata),
    .frame_start(frame_start),
    .pixel_valid(pixel_valid),
    .pixel_x    (pixel_x),
    .pixel_y    (pixel_y),
    .rgb        (rgb),
    .rgb_valid  (rgb_valid),
    .coll_status(coll_status),
    .frame_cnt  (frame_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cap[$];

  // Model state: shadow and active sprite sets, the pixel in flight, outputs.
  int m_sx[N], m_sy[N], m_shx[N], m_shy[N], m_scol[N];
  bit m_sen[N];
  int m_ax[N], m_ay[N], m_ahx[N], m_ahy[N], m_acol[N];
  bit m_aen[N];
  bit m_s1_valid;
  bit m_s1_hit[N];
  int m_s1_col;
  int exp_rgb, exp_coll, exp_cnt, m_acc;
  bit exp_valid;
  bit model_ready = 1'b0;

  function automatic bit covers(int c, int h, int p);
    int lo;
    lo = c - h;
    if (lo < 0) lo = 0;
    return (p >= lo) && (p <= c + h);
  endfunction

  task automatic checkOutput(string name, logic [31:0] actual, logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic checkCapture(string name, int expq[$]);
    checkOutput({name, "_count"}, cap.size(), expq.size());
    for (int i = 0; i < expq.size() && i < cap.size(); i++) begin
      checkOutput($sformatf("%s[%0d]", name, i), cap[i], expq[i]);
    end
    cap.delete();
  endtask

  // Behavioural model: a pixel accepted at one edge shows up at the next
  // one; collisions are judged on the pixel that is one edge old.
  always @(posedge clk) begin : model
    int coll_now, nhit, idx, fld;
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        m_sx[i] = 0; m_sy[i] = 0; m_shx[i] = 0; m_shy[i] = 0; m_scol[i] = 0; m_sen[i] = 0;
        m_ax[i] = 0; m_ay[i] = 0; m_ahx[i] = 0; m_ahy[i] = 0; m_acol[i] = 0; m_aen[i] = 0;
        m_s1_hit[i] = 0;
      end
      m_s1_valid = 0; m_s1_col = BG;
      exp_rgb = BG; exp_valid = 0; exp_coll = 0; exp_cnt = 0; m_acc = 0;
      model_ready = 1'b1;
    end else begin
      nhit = 0;
      for (int i = 0; i < N; i++) if (m_s1_hit[i]) nhit++;
      coll_now = 0;
      if (m_s1_valid && nhit >= 2)
        for (int i = 0; i < N; i++) if (m_s1_hit[i]) coll_now |= (1 << i);
      exp_valid = m_s1_valid;
      exp_rgb   = m_s1_valid ? m_s1_col : BG;
      if (frame_start) begin
        exp_coll = m_acc;
        m_acc    = coll_now;
        exp_cnt  = (exp_cnt + 1) % 65536;
        for (int i = 0; i < N; i++) begin
          m_ax[i] = m_sx[i]; m_ay[i] = m_sy[i]; m_ahx[i] = m_shx[i];
          m_ahy[i] = m_shy[i]; m_acol[i] = m_scol[i]; m_aen[i] = m_sen[i];
        end
      end else begin
        m_acc |= coll_now;
      end
      m_s1_valid = pixel_valid;
      m_s1_col   = BG;
      for (int i = N - 1; i >= 0; i--) begin
        m_s1_hit[i] = pixel_valid && m_aen[i] &&
                      covers(m_ax[i], m_ahx[i], int'(pixel_x)) &&
                      covers(m_ay[i], m_ahy[i], int'(pixel_y));
        if (m_s1_hit[i]) m_s1_col = m_acol[i];
      end
      if (cfg_we) begin
        idx = int'(cfg_addr) / 4;
        fld = int'(cfg_addr) % 4;
        if (idx < N) begin
          case (fld)
            0: begin m_sx[idx] = cfg_wdata % 1024; m_sy[idx] = (cfg_wdata / 1024) % 1024; end
            1: begin m_shx[idx] = cfg_wdata % 256; m_shy[idx] = (cfg_wdata / 256) % 256; end
            2: begin m_scol[idx] = cfg_wdata % 4096; m_sen[idx] = cfg_wdata[31]; end
            default: ;
          endcase
        end
      end
    end
  end

  // Compare process: every cycle after the first reset, outputs against model.
  always @(posedge clk) begin
    #1;
    if (model_ready) begin
      checkOutput("rgb_valid",   rgb_valid,   exp_valid);
      checkOutput("rgb",         rgb,         exp_rgb);
      checkOutput("coll_status", coll_status, exp_coll);
      checkOutput("frame_cnt",   frame_cnt,   exp_cnt);
      if (rgb_valid) cap.push_back(int'(rgb));
    end
  end

  task automatic applyStimulus(bit r, bit we, int addr, int wdata, bit fs, bit pv, int px, int py);
    @(negedge clk);
    rst         = r;
    cfg_we      = we;
    cfg_addr    = 4'(addr);
    cfg_wdata   = wdata;
    frame_start = fs;
    pixel_valid = pv;
    pixel_x     = 10'(px);
    pixel_y     = 10'(py);
  endtask

  task automatic idle(int n);
    repeat (n) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic pix(int x, int y);
    applyStimulus(0, 0, 0, 0, 0, 1, x, y);
  endtask

  task automatic wr(int idx, int fld, int data);
    applyStimulus(0, 1, idx * 4 + fld, data, 0, 0, 0, 0);
  endtask

  task automatic fs();
    applyStimulus(0, 0, 0, 0, 1, 0, 0, 0);
  endtask

  function automatic int rand_coord();
    return ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 1023)) : int'($urandom_range(0, 63));
  endfunction

  initial begin
    int expq[$];
    int fld, wdata;

    // Reset, then an idle-screen stream with bubbles.
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
    idle(1);
    cap.delete();
    pix(10, 10); idle(1); pix(11, 10); pix(12, 10); idle(1); pix(13, 10);
    idle(3);
    expq = '{BG, BG, BG, BG};
    checkCapture("bg_stream", expq);
    checkOutput("reset_coll", coll_status, 0);
    checkOutput("reset_cnt", frame_cnt, 0);

    // Single sprite edges on row 50.
    wr(0, 0, (50 << 10) | 100);
    wr(0, 1, (7 << 8) | 7);
    wr(0, 2, 32'h8000_0FFF);
    fs();
    for (int x = 92; x <= 108; x++) pix(x, 50);
    idle(3);
    expq.delete();
    for (int x = 92; x <= 108; x++) expq.push_back((x >= 93 && x <= 107) ? 12'hFFF : BG);
    checkCapture("edge_scan", expq);
    checkOutput("cnt_after_commit", frame_cnt, 1);

    // Left edge saturates at 0, right edge runs off screen without wrapping.
    wr(0, 2, 0);
    wr(1, 0, (3 << 10) | 3);
    wr(1, 1, 5);
    wr(1, 2, 32'h8000_00A0);
    wr(2, 0, (20 << 10) | 1020);
    wr(2, 1, 7);
    wr(2, 2, 32'h8000_000B);
    fs();
    expq.delete();
    for (int x = 0; x <= 9; x++) begin pix(x, 3); expq.push_back(x <= 8 ? 12'h0A0 : BG); end
    for (int x = 0; x <= 4; x++) begin pix(x, 20); expq.push_back(BG); end
    for (int x = 1010; x <= 1023; x++) begin pix(x, 20); expq.push_back(x >= 1013 ? 12'h00B : BG); end
    idle(3);
    checkCapture("sat_wrap", expq);

    // Overlap priority and collision publication.
    wr(1, 2, 0);
    wr(2, 2, 0);
    wr(0, 0, (200 << 10) | 200);
    wr(0, 1, (2 << 8) | 2);
    wr(0, 2, 32'h8000_0F00);
    wr(1, 0, (200 << 10) | 202);
    wr(1, 1, (2 << 8) | 2);
    wr(1, 2, 32'h8000_00F0);
    fs();
    pix(200, 200); pix(203, 200);
    idle(3);
    expq = '{12'hF00, 12'h0F0};
    checkCapture("overlap", expq);
    fs();
    @(posedge clk); #2;
    checkOutput("coll_pair", coll_status, 4'b0011);
    checkOutput("cnt_four", frame_cnt, 4);

    // Mid-frame write waits for the commit; a write in the commit cycle
    // waits for the next one, while the commit-cycle pixel sees new values.
    wr(0, 0, (300 << 10) | 300);
    pix(200, 200);
    applyStimulus(0, 1, 0, (400 << 10) | 400, 1, 1, 300, 300);
    pix(400, 400); pix(300, 300);
    idle(1); fs(); pix(400, 400);
    idle(3);
    expq = '{12'hF00, 12'hF00, BG, 12'hF00, 12'hF00};
    checkCapture("commit_timing", expq);

    // Reset while streaming with sprites active.
    pix(400, 400);
    applyStimulus(1, 0, 0, 0, 0, 1, 400, 400);
    @(posedge clk); #2;
    checkOutput("rst_valid", rgb_valid, 0);
    checkOutput("rst_cnt", frame_cnt, 0);
    checkOutput("rst_coll", coll_status, 0);
    cap.delete();
    applyStimulus(0, 0, 0, 0, 0, 1, 400, 400);
    idle(3);
    expq = '{BG};
    checkCapture("after_rst", expq);

    // Randomized traffic; the compare process checks every cycle.
    repeat (4000) begin
      fld = int'($urandom_range(0, 3));
      case (fld)
        0: wdata = int'($urandom & 32'hFFF0_0000) | (rand_coord() << 10) | rand_coord();
        1: wdata = int'($urandom & 32'hFFFF_0000) | (int'($urandom_range(0, 15)) << 8) | int'($urandom_range(0, 15));
        default: wdata = int'($urandom);
      endcase
      applyStimulus($urandom_range(0, 999) < 3,
                    $urandom_range(0, 3) == 0,
                    int'($urandom_range(0, N - 1)) * 4 + fld,
                    wdata,
                    $urandom_range(0, 99) == 0,
                    $urandom_range(0, 3) != 0,
                    rand_coord(), rand_coord());
    end
    idle(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
